// File: rtl/minn_pkg.sv
// Shared width helpers and FSM encoding for the Minn sliding-window accumulator.
package minn_pkg;

  function automatic int len_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int sum_w(input int width, input int max_depth);
    return width + len_w(max_depth);
  endfunction

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_e;

endpackage

// File: rtl/minn_window_ram.sv
// Window sample store: one write port, one combinational read port, no reset.
module minn_window_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 32,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/minn_running_sum_cfg.sv
// Multi-lane sliding-window running sum with runtime window length and restart.
module minn_running_sum_cfg
  import minn_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MAX_DEPTH = 64,
  parameter  int CHANNELS  = 2,
  localparam int LEN_W     = len_w(MAX_DEPTH),
  localparam int SUM_W     = sum_w(WIDTH, MAX_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      cfg_load,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  output logic [CHANNELS*SUM_W-1:0] sum_out,
  output logic                      out_valid,
  output logic                      sum_valid,
  output logic [LEN_W-1:0]          cur_len
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  state_e                             state_q, state_d;
  logic [LEN_W-1:0]                   len_q, len_d;
  logic [LEN_W-1:0]                   fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [CHANNELS-1:0][SUM_W-1:0]     sum_q, sum_d;
  logic                               out_valid_q, out_valid_d;
  logic                               sum_valid_q, sum_valid_d;

  logic [CHANNELS*WIDTH-1:0]          oldest_raw;
  logic [CHANNELS-1:0][SUM_W-1:0]     sum_nxt;
  logic                               accept;
  logic [LEN_W-1:0]                   fill_inc;

  assign accept   = in_valid & ~cfg_load;
  assign fill_inc = fill_cnt_q + LEN_W'(1);

  minn_window_ram #(
    .DEPTH(MAX_DEPTH),
    .DW   (CHANNELS*WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_ptr_q),
    .wdata(sample_in),
    .raddr(wr_ptr_q),
    .rdata(oldest_raw)
  );

  // During FILL the slot under wr_ptr may hold a previous window's data, so it is masked.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] smp, old;
    assign smp = sample_in[c*WIDTH +: WIDTH];
    assign old = (state_q == RUN) ? oldest_raw[c*WIDTH +: WIDTH] : '0;
    assign sum_nxt[c] = sum_q[c]
                      + {{(SUM_W-WIDTH){smp[WIDTH-1]}}, smp}
                      - {{(SUM_W-WIDTH){old[WIDTH-1]}}, old};
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    fill_cnt_d  = fill_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    sum_valid_d = sum_valid_q;
    if (cfg_load) begin
      if (cfg_len == '0)                     len_d = LEN_W'(1);
      else if (cfg_len > LEN_W'(MAX_DEPTH))  len_d = LEN_W'(MAX_DEPTH);
      else                                   len_d = cfg_len;
      state_d     = FILL;
      fill_cnt_d  = '0;
      wr_ptr_d    = '0;
      sum_d       = '0;
      sum_valid_d = 1'b0;
    end else if (in_valid) begin
      sum_d       = sum_nxt;
      out_valid_d = 1'b1;
      wr_ptr_d    = (LEN_W'(wr_ptr_q) == len_q - LEN_W'(1)) ? '0 : wr_ptr_q + AW'(1);
      if (state_q == FILL) begin
        fill_cnt_d = fill_inc;
        if (fill_inc == len_q) begin
          state_d     = RUN;
          sum_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      len_q       <= LEN_W'(MAX_DEPTH);
      fill_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      fill_cnt_q  <= fill_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_out   = sum_q;
  assign out_valid = out_valid_q;
  assign sum_valid = sum_valid_q;
  assign cur_len   = len_q;

endmodule

// File: tb/tb_minn_running_sum_cfg.sv
// Bench for minn_running_sum_cfg: queue-based window model checked every cycle plus literal pins.
module tb_minn_running_sum_cfg;

  localparam int WIDTH = 16, MAX_DEPTH = 64, CHANNELS = 2;
  localparam int LEN_W = 7, SUM_W = 23;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [LEN_W-1:0]          cfg_len = '0;
  logic                      cfg_load = 1'b0;
  logic                      in_valid = 1'b0;
  logic [CHANNELS*WIDTH-1:0] sample_in = '0;
  logic [CHANNELS*SUM_W-1:0] sum_out;
  logic                      out_valid, sum_valid;
  logic [LEN_W-1:0]          cur_len;

  minn_running_sum_cfg #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_load(cfg_load), .in_valid(in_valid),
    .sample_in(sample_in), .sum_out(sum_out), .out_valid(out_valid), .sum_valid(sum_valid),
    .cur_len(cur_len)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint lane(input int c);
    logic [SUM_W-1:0] v;
    v = sum_out[c*SUM_W +: SUM_W];
    return longint'($signed(v));
  endfunction

  // Model: a window is simply the last len accepted samples since the last restart.
  int q0[$], q1[$];
  int m_len = MAX_DEPTH;
  longint m_s0 = 0, m_s1 = 0;
  bit m_ov = 0, m_sv = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_len = MAX_DEPTH; q0.delete(); q1.delete();
      m_s0 = 0; m_s1 = 0; m_ov = 0; m_sv = 0;
    end else if (cfg_load) begin
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_DEPTH) ? MAX_DEPTH : int'(cfg_len));
      q0.delete(); q1.delete();
      m_s0 = 0; m_s1 = 0; m_ov = 0; m_sv = 0;
    end else if (in_valid) begin
      q0.push_back(int'($signed(sample_in[15:0])));
      q1.push_back(int'($signed(sample_in[31:16])));
      if (q0.size() > m_len) begin void'(q0.pop_front()); void'(q1.pop_front()); end
      m_s0 = 0; m_s1 = 0;
      foreach (q0[i]) m_s0 += q0[i];
      foreach (q1[i]) m_s1 += q1[i];
      m_ov = 1;
      m_sv = (q0.size() == m_len);
    end else begin
      m_ov = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_sum0", lane(0), m_s0);
      chk("model_sum1", lane(1), m_s1);
      chk("model_out_valid", longint'(out_valid), longint'(m_ov));
      chk("model_sum_valid", longint'(sum_valid), longint'(m_sv));
      chk("model_cur_len", longint'(cur_len), longint'(m_len));
    end
  end

  task automatic step(input bit v, input int s0, input int s1, input bit ld = 0, input int len = 0);
    in_valid  = v;
    sample_in = {16'(s1), 16'(s0)};
    cfg_load  = ld;
    cfg_len   = LEN_W'(len);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; cfg_load = 0;
  endtask

  initial begin
    int e4[6]  = '{1, 3, 6, 10, 14, 18};
    int gs[7]  = '{5, 0, 0, 7, 0, 9, 11};
    int gv[7]  = '{1, 0, 0, 1, 0, 1, 1};
    int ge[7]  = '{5, 5, 5, 12, 12, 21, 27};
    int re[3]  = '{8, 17, 19};

    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sum0", lane(0), 0);
    chk("rst_sum1", lane(1), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum_valid", longint'(sum_valid), 0);
    chk("rst_cur_len", longint'(cur_len), 64);
    rst = 0;
    chk_en = 1;

    // len=4 basic window, lane1 mirrors with negatives
    step(0, 0, 0, 1, 4);
    chk("load4_cur_len", longint'(cur_len), 4);
    for (int i = 0; i < 6; i++) begin
      step(1, i + 1, -(i + 1));
      chk("l4_sum0", lane(0), e4[i]);
      chk("l4_sum1", lane(1), -e4[i]);
      chk("l4_out_valid", longint'(out_valid), 1);
      chk("l4_sum_valid", longint'(sum_valid), (i >= 3) ? 1 : 0);
    end

    // Gaps with len=3
    step(0, 0, 0, 1, 3);
    for (int i = 0; i < 7; i++) begin
      step(gv[i][0], gs[i], 0);
      chk("gap_sum0", lane(0), ge[i]);
      chk("gap_out_valid", longint'(out_valid), gv[i]);
    end

    // Reload mid-window with a colliding sample
    step(0, 0, 0, 1, 4);
    for (int i = 0; i < 6; i++) step(1, i + 1, i + 1);
    step(1, 100, 100, 1, 2);
    chk("reload_sum_valid", longint'(sum_valid), 0);
    chk("reload_sum0", lane(0), 0);
    chk("reload_out_valid", longint'(out_valid), 0);
    chk("reload_cur_len", longint'(cur_len), 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 8 + i, 0);
      chk("reload_seq_sum0", lane(0), re[i]);
      chk("reload_seq_sv", longint'(sum_valid), (i >= 1) ? 1 : 0);
    end

    // Clamp low and high
    step(0, 0, 0, 1, 0);
    chk("clamp0_cur_len", longint'(cur_len), 1);
    step(1, 3, 0);
    chk("len1_sum0_a", lane(0), 3);
    chk("len1_sv_a", longint'(sum_valid), 1);
    step(1, -4, 0);
    chk("len1_sum0_b", lane(0), -4);
    step(0, 0, 0, 1, 100);
    chk("clamp100_cur_len", longint'(cur_len), 64);

    // Full-scale extremes at len=64
    for (int i = 0; i < 67; i++) step(1, -32768, -32768);
    chk("neg_full_sum0", lane(0), -2097152);
    chk("neg_full_sum1", lane(1), -2097152);
    for (int i = 0; i < 64; i++) step(1, 32767, 32767);
    chk("pos_full_sum0", lane(0), 2097088);
    chk("pos_full_sv", longint'(sum_valid), 1);

    // Reset mid-RUN
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("mrst_sum0", lane(0), 0);
    chk("mrst_sum_valid", longint'(sum_valid), 0);
    chk("mrst_out_valid", longint'(out_valid), 0);
    chk("mrst_cur_len", longint'(cur_len), 64);
    step(1, 7, 0);
    chk("mrst_first_sum0", lane(0), 7);
    chk("mrst_first_sv", longint'(sum_valid), 0);

    step(0, 0, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/minn_running_sum_cfg.md
Name: minn_running_sum_cfg

Overview:
Multi-channel sliding-window accumulator for the Minn timing-metric path. It is the generalised successor of the fixed-depth running sum, with the following changes:
- CHANNELS lanes (e.g. I/Q or per-antenna) share one write pointer.
- Window length is set at runtime, up to MAX_DEPTH.
- The window can be restarted without a memory clear.

It sits between the correlator product stage and the metric normaliser.

Parameters:
WIDTH, 16, signed sample width per channel
MAX_DEPTH, 64, maximum window length (>=1); sets RAM depth
CHANNELS, 2, number of parallel lanes (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_len  in  LEN_W=$clog2(MAX_DEPTH+1)  requested window length
cfg_load  in  1  pulse: apply cfg_len and restart the window
in_valid  in  1  sample strobe
sample_in  in  CHANNELS*WIDTH  packed signed samples; lane c at [c*WIDTH +: WIDTH]
sum_out  out  CHANNELS*SUM_W  packed signed sums; SUM_W = WIDTH+LEN_W
out_valid  out  1  one-cycle pulse: sum_out updated
sum_valid  out  1  window full; sum_out covers exactly len samples
cur_len  out  LEN_W  active window length

Behaviour:
- Reset (clk, rst sync active-high) values:
  - sum_out = 0, out_valid = 0, sum_valid = 0.
  - cur_len = MAX_DEPTH, wr_ptr = 0, fill_cnt = 0, state = FILL.
  - RAM contents are not reset.
- FSM states:
  - FILL: fill_cnt < len.
  - RUN: window full.
- Transitions:
  - FILL->RUN when an accepted sample makes fill_cnt == len.
  - Any state->FILL on cfg_load.
- Accepted sample (in_valid=1, cfg_load=0), per lane c:
  - oldest_c = RAM[wr_ptr] lane c in RUN, and forced to 0 in FILL.
  - next_c = sum_c + sext(sample_c) - sext(oldest_c), computed in SUM_W bits; it cannot overflow.
  - RAM[wr_ptr] <= sample.
  - wr_ptr wraps to 0 after len-1, not after MAX_DEPTH-1.
- Latency:
  - sum_out and out_valid are registered one cycle after the accepted sample.
  - sum_valid rises on the same edge as the out_valid that carries the len-th sample's sum.
- Idle (in_valid=0): sum_out holds, out_valid = 0, sum_valid holds.
- cfg_load:
  - len <= clamp(cfg_len): 0 becomes 1, and values > MAX_DEPTH become MAX_DEPTH.
  - wr_ptr <= 0, fill_cnt <= 0, all internal sums <= 0, sum_out <= 0.
  - sum_valid <= 0, out_valid <= 0, state <= FILL.
- Simultaneous cfg_load and in_valid: cfg_load wins and the sample is dropped.
- cfg_load issued mid-window discards the partial window. Stale RAM is never read, because oldest is masked during FILL.
- len = 1: sum_out equals the current sample from the first sample onward, and sum_valid rises after the first sample.
- Reset mid-stream: same as the reset values above; the next sample starts a new FILL.
- RAM read of wr_ptr is combinational or same-cycle. A registered read is allowed only if the stated latency is preserved.

Decomposition:
- Package minn_pkg holds:
  - function len_w(max_depth) = $clog2(max_depth+1);
  - function sum_w(width, max_depth) = width + len_w(max_depth);
  - typedef of the FSM enum {FILL, RUN}.
- One sub-module, minn_window_ram:
  - MAX_DEPTH x (CHANNELS*WIDTH);
  - single write port, one async-read port, no reset.

Test Plan:
- Reset, cfg_len=4 load, CH0 samples 1,2,3,4,5,6 -> sum_out 1,3,6,10,14,18; sum_valid first high with 10; out_valid 6 pulses; CH1 independent (feed -1.. gives -1,-3,-6,-10,-14,-18).
- WIDTH=16, len=MAX_DEPTH=64, all samples -32768 -> sum_out -2097152 after 64 samples, stays there, no overflow; all +32767 -> 2097088.
- Gaps: len=3, samples 5,_,_,7,_,9,11 (_ = in_valid low) -> sums 5,12,21,27; sum_out held and out_valid low during gaps.
- Reload mid-window: len=4 after 6 samples, then cfg_load len=2 with simultaneous in_valid -> sample dropped; sum_valid=0; next samples 8,9,10 -> 8,17,19; sum_valid high at 17.
- Clamp: cfg_len=0 -> cur_len=1, sum_out tracks sample; cfg_len=100 with MAX_DEPTH=64 -> cur_len=64.
- rst asserted mid-RUN -> next cycle all outputs 0, cur_len=64; first new sample 7 -> sum_out 7, sum_valid 0.
